// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver: shadow/display double buffer, frame-aligned swap, blanking gap.
// Optional SEG7_LZB_EN: blank the tens digit when it is zero (leading-zero blanking).
module seg7_scan_driver #(
    parameter int CLK_FREQ       = 10_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] digit_lo,
    input  logic [3:0] digit_hi,
    output logic [7:0] seg_out,
    output logic       frame_start
);

    localparam int DIV   = CLK_FREQ / REFRESH_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW_LAST  = CNT_W'(DIV - BLANK_CYCLES - 1);
    localparam logic [6:0]       SEG_POLARITY   = {7{SEG_ACTIVE_LOW}};
    localparam logic [7:0]       SEG_OFF        = {1'b0, SEG_POLARITY};

    generate
        if (DIV < BLANK_CYCLES + 2) begin : g_bad_div
            $error("seg7_scan_driver: slot length DIV must be at least BLANK_CYCLES+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        SHOW_LO  = 2'd0,
        BLANK_LO = 2'd1,
        SHOW_HI  = 2'd2,
        BLANK_HI = 2'd3
    } state_e;

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [7:0]       shadow_q,      shadow_d;
    logic [7:0]       display_q,     display_d;
    logic             pending_q,     pending_d;
    logic [7:0]       seg_q,         seg_d;
    logic             frame_start_q, frame_start_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    logic       cnt_wrap;
    logic       frame_wrap;
    logic [6:0] segs_on;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        shadow_d      = shadow_q;
        display_d     = display_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        segs_on       = 7'h00;

        cnt_wrap   = (cnt_q == CNT_LAST);
        frame_wrap = cnt_wrap && (state_q == BLANK_HI);
        if (cnt_wrap) cnt_d = '0;

        unique case (state_q)
            SHOW_LO:  if (cnt_q == CNT_SHOW_LAST) state_d = BLANK_LO;
            BLANK_LO: if (cnt_wrap)               state_d = SHOW_HI;
            SHOW_HI:  if (cnt_q == CNT_SHOW_LAST) state_d = BLANK_HI;
            BLANK_HI: if (cnt_wrap)               state_d = SHOW_LO;
            default:                              state_d = SHOW_LO;
        endcase

        // Swap reads the old shadow; a coincident load lands in shadow and stays pending.
        if (frame_wrap) begin
            frame_start_d = 1'b1;
            if (pending_q) begin
                display_d = shadow_q;
                pending_d = 1'b0;
            end
        end
        if (load) begin
            shadow_d  = {digit_hi, digit_lo};
            pending_d = 1'b1;
        end

        if (state_q == SHOW_LO) begin
            segs_on = hex_decode(display_q[3:0]);
        end else if (state_q == SHOW_HI) begin
`ifdef SEG7_LZB_EN
            if (display_q[7:4] != 4'h0) segs_on = hex_decode(display_q[7:4]);
`else
            segs_on = hex_decode(display_q[7:4]);
`endif
        end
        seg_d = {state_q[1], segs_on ^ SEG_POLARITY};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SHOW_LO;
            cnt_q         <= '0;
            shadow_q      <= '0;
            display_q     <= '0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: active-high and active-low instances against a frame-position model.
module tb_seg7_scan_driver;

    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] digit_lo = 4'h0;
    logic [3:0] digit_hi = 4'h0;
    logic [7:0] seg_ah, seg_al;
    logic       fs_ah, fs_al;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLK_FREQ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b0)
    ) dut_ah (
        .clk(clk), .rst_n(rst_n), .load(load), .digit_lo(digit_lo), .digit_hi(digit_hi),
        .seg_out(seg_ah), .frame_start(fs_ah)
    );

    seg7_scan_driver #(
        .CLK_FREQ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .load(load), .digit_lo(digit_lo), .digit_hi(digit_hi),
        .seg_out(seg_al), .frame_start(fs_al)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", tag, $time, act, exp);
        end
    endtask

    // Reference model: position within the frame decides slot, blanking and swap.
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         t;
    logic [7:0] m_shadow, m_disp;
    bit         m_pend;

    task automatic model_reset();
        t        = 0;
        m_shadow = 8'h00;
        m_disp   = 8'h00;
        m_pend   = 1'b0;
    endtask

    function automatic logic [7:0] model_seg(input int p);
        int         slot;
        logic [3:0] dig;
        logic [6:0] segs;
        slot = p / DIV;
        dig  = (slot == 1) ? m_disp[7:4] : m_disp[3:0];
        segs = ((p % DIV) < DIV - BLANK) ? hex_tbl[dig] : 7'h00;
`ifdef SEG7_LZB_EN
        if (slot == 1 && dig == 4'h0) segs = 7'h00;
`endif
        return {slot[0], segs};
    endfunction

    task automatic tick(input bit ld, input logic [3:0] lo, input logic [3:0] hi);
        int         p;
        logic [7:0] exp_seg;
        logic       exp_fs;
        load     = ld;
        digit_lo = lo;
        digit_hi = hi;
        @(posedge clk);
        p       = t % FRAME;
        exp_seg = model_seg(p);
        exp_fs  = (p == FRAME - 1);
        if (exp_fs && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_shadow = {hi, lo};
            m_pend   = 1'b1;
        end
        t++;
        @(negedge clk);
        load = 1'b0;
        check("seg_ah", seg_ah, exp_seg);
        check("seg_al", seg_al, exp_seg ^ 8'h7F);
        check("fs_ah", {7'b0, fs_ah}, {7'b0, exp_fs});
        check("fs_al", {7'b0, fs_al}, {7'b0, exp_fs});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 4'h0);
    endtask

    task automatic advance_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) tick(1'b0, 4'h0, 4'h0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            tick($urandom_range(7) == 0, 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_seg_ah", seg_ah, 8'h00);
        check("rst_seg_al", seg_al, 8'h7F);
        check("rst_fs", {7'b0, fs_ah}, 8'h00);
        rst_n = 1'b1;

        idle(2 * FRAME);

        // Load 7/4 mid-frame, then a double load where only 5/9 must survive.
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 5)               tick(1'b1, 4'h7, 4'h4);
            else if (i == FRAME + 3)  tick(1'b1, 4'h2, 4'h1);
            else if (i == FRAME + 12) tick(1'b1, 4'h5, 4'h9);
            else                      tick(1'b0, 4'h0, 4'h0);
        end

        // Load exactly on the swap edge: applied one frame later.
        advance_to(FRAME - 1);
        tick(1'b1, 4'h3, 4'h3);
        idle(2 * FRAME + 3);

        // Tens digit zero exercises leading-zero handling in either build.
        tick(1'b1, 4'h8, 4'h0);
        idle(2 * FRAME);

        random_run(400);

        // Asynchronous reset in the middle of a tens slot.
        tick(1'b1, 4'hA, 4'hC);
        idle(FRAME);
        advance_to(DIV + 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg_ah", seg_ah, 8'h00);
        check("async_seg_al", seg_al, 8'h7F);
        check("async_fs", {7'b0, fs_ah}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(FRAME + 2);
        random_run(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
